// File: rtl/bus_term_fifo.sv
// bus_term_fifo: per-terminal port between one host terminal and one bus
// driver slot. The TX buffer queues host packets for the bus. The RX buffer
// keeps the bus deliveries addressed to this terminal or to broadcast.

// Show-ahead circular buffer with an occupancy count and a saturating drop
// counter. A write while full is accepted only when a read frees a slot in
// the same cycle.
module bus_term_fifo_buf #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         not_empty,
    output logic         full,
    output logic         underflow,
    output logic [7:0]   drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic          do_wr, do_rd, drop, empty;

    // Next-state logic: accept/drop decisions, pointer and count updates.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        drop_cnt_d = drop_cnt_q;

        empty     = (cnt_q == '0);
        full      = (cnt_q == CW'(DEPTH));
        do_rd     = rd_en && !empty;
        do_wr     = reset && wr_en && (!full || rd_en);
        drop      = wr_en && full && !rd_en;
        underflow = rd_en && empty;

        if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
        cnt_d = cnt_q + CW'(do_wr) - CW'(do_rd);
        if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            drop_cnt_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; stale entries are never visible because the head is masked by empty.
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    // Show-ahead head, forced to zero while empty.
    always_comb begin
        not_empty = !empty;
        rd_data   = empty ? '0 : mem_q[rd_ptr_q];
        drop_cnt  = drop_cnt_q;
    end
endmodule

// Top: TX and RX buffers, destination filter and sticky underflow flag.
module bus_term_fifo #(
    parameter int         pckg_sz = 16,
    parameter int         depth   = 8,
    parameter logic [7:0] id      = 8'd0,
    parameter logic [7:0] bcast   = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               h_push,
    input  logic [pckg_sz-1:0] h_din,
    output logic               h_full,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               h_pop,
    output logic [pckg_sz-1:0] h_dout,
    output logic               h_valid,
    output logic [7:0]         tx_ovf_cnt,
    output logic [7:0]         rx_drop_cnt,
    output logic               err_underflow
);
    logic [7:0] dest;
    logic       rx_accept;
    logic       tx_uf, rx_uf;
    logic       rx_full;
    logic       err_underflow_q, err_underflow_d;

    // Destination filter and sticky underflow next state.
    always_comb begin
        dest            = D_push[pckg_sz-1 -: 8];
        rx_accept       = push && ((dest == id) || (dest == bcast));
        err_underflow_d = err_underflow_q | tx_uf | rx_uf;
    end

    // Sticky underflow register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) err_underflow_q <= 1'b0;
        else        err_underflow_q <= err_underflow_d;
    end

    assign err_underflow = err_underflow_q;

    bus_term_fifo_buf #(.W(pckg_sz), .DEPTH(depth)) u_tx (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (h_push),
        .wr_data   (h_din),
        .rd_en     (pop),
        .rd_data   (D_pop),
        .not_empty (pndng),
        .full      (h_full),
        .underflow (tx_uf),
        .drop_cnt  (tx_ovf_cnt)
    );

    // RX full is not exported; the host only sees h_valid and the drop count.
    bus_term_fifo_buf #(.W(pckg_sz), .DEPTH(depth)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (rx_accept),
        .wr_data   (D_push),
        .rd_en     (h_pop),
        .rd_data   (h_dout),
        .not_empty (h_valid),
        .full      (rx_full),
        .underflow (rx_uf),
        .drop_cnt  (rx_drop_cnt)
    );

    logic unused_ok;
    assign unused_ok = rx_full;
endmodule
